// File: rtl/mdu_div_arbiter.sv
// Round-robin arbiter placing two requesters in front of one shared iterative divider,
// with a one-entry quotient/remainder cache so a paired DIV/REM skips the second divide.
module mdu_div_arbiter #(
  parameter int XLEN     = 64,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,

  input  logic            r0_valid,
  output logic            r0_ready,
  input  logic            r0_w,
  input  logic            r0_signed,
  input  logic            r0_rem,
  input  logic [XLEN-1:0] r0_a,
  input  logic [XLEN-1:0] r0_b,
  output logic            r0_res_valid,
  input  logic            r0_res_ready,
  output logic [XLEN-1:0] r0_res,

  input  logic            r1_valid,
  output logic            r1_ready,
  input  logic            r1_w,
  input  logic            r1_signed,
  input  logic            r1_rem,
  input  logic [XLEN-1:0] r1_a,
  input  logic [XLEN-1:0] r1_b,
  output logic            r1_res_valid,
  input  logic            r1_res_ready,
  output logic [XLEN-1:0] r1_res,

  output logic            d_valid,
  input  logic            d_ready,
  output logic            d_w,
  output logic            d_signed,
  output logic [XLEN-1:0] d_a,
  output logic [XLEN-1:0] d_b,
  input  logic            d_done,
  input  logic [XLEN-1:0] d_q,
  input  logic [XLEN-1:0] d_r,
  output logic            d_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t            state, state_d;
  logic              ptr;
  logic              owner;

  logic              cap_w;
  logic              cap_signed;
  logic              cap_rem;
  logic [XLEN-1:0]   cap_a;
  logic [XLEN-1:0]   cap_b;
  logic [XLEN-1:0]   res_q;

  logic              cache_valid;
  logic              cache_w;
  logic              cache_signed;
  logic [XLEN-1:0]   cache_a;
  logic [XLEN-1:0]   cache_b;
  logic [XLEN-1:0]   cache_q;
  logic [XLEN-1:0]   cache_r;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel_w;
  logic              sel_signed;
  logic              sel_rem;
  logic [XLEN-1:0]   sel_a;
  logic [XLEN-1:0]   sel_b;
  logic              cache_hit;
  logic              res_hs;
  logic              cache_wr;

  // Requests are only taken in IDLE, and never in a flush cycle.
  // NOTE: every signal driven in an always_comb gets a default first so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_IDLE && !flush) begin
      if (!ptr) begin
        grant0 = r0_valid;
        grant1 = r1_valid & ~r0_valid;
      end else begin
        grant1 = r1_valid;
        grant0 = r0_valid & ~r1_valid;
      end
    end
  end

  assign accept   = grant0 | grant1;
  assign r0_ready = grant0;
  assign r1_ready = grant1;

  assign sel_w      = grant1 ? r1_w      : r0_w;
  assign sel_signed = grant1 ? r1_signed : r0_signed;
  assign sel_rem    = grant1 ? r1_rem    : r0_rem;
  assign sel_a      = grant1 ? r1_a      : r0_a;
  assign sel_b      = grant1 ? r1_b      : r0_b;

  // The tag excludes rem: one divide yields both quotient and remainder.
  assign cache_hit = CACHE_EN && cache_valid &&
                     (cache_w == sel_w) && (cache_signed == sel_signed) &&
                     (cache_a == sel_a) && (cache_b == sel_b);

  assign res_hs   = (state == S_RESP) && (owner ? r1_res_ready : r0_res_ready);
  assign cache_wr = (state == S_BUSY) && d_done && !flush;

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: begin
        if (accept) state_d = cache_hit ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        if (flush)        state_d = S_IDLE;
        else if (d_ready) state_d = S_BUSY;
      end
      S_BUSY: begin
        // The divider cannot abort; a flush waits out its result unless it lands now.
        if (flush)       state_d = d_done ? S_IDLE : S_DRAIN;
        else if (d_done) state_d = S_RESP;
      end
      S_DRAIN: begin
        if (d_done) state_d = S_IDLE;
      end
      S_RESP: begin
        if (flush || res_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign d_valid  = (state == S_ISSUE);
  assign d_ack    = (state == S_BUSY) || (state == S_DRAIN);
  assign d_w      = cap_w;
  assign d_signed = cap_signed;
  assign d_a      = cap_a;
  assign d_b      = cap_b;

  assign r0_res_valid = (state == S_RESP) && !owner;
  assign r1_res_valid = (state == S_RESP) &&  owner;
  assign r0_res       = res_q;
  assign r1_res       = res_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      ptr         <= 1'b0;
      owner       <= 1'b0;
      cap_w       <= 1'b0;
      cap_signed  <= 1'b0;
      cap_rem     <= 1'b0;
      cap_a       <= '0;
      cap_b       <= '0;
      res_q       <= '0;
      cache_valid <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        owner      <= grant1;
        cap_w      <= sel_w;
        cap_signed <= sel_signed;
        cap_rem    <= sel_rem;
        cap_a      <= sel_a;
        cap_b      <= sel_b;
        if (cache_hit) res_q <= sel_rem ? cache_r : cache_q;
      end
      if (cache_wr) res_q <= cap_rem ? d_r : d_q;
      if (res_hs && !flush) ptr <= ~owner;
      if (flush)         cache_valid <= 1'b0;
      else if (cache_wr) cache_valid <= 1'b1;
    end
  end

  // NOTE: the cache payload is deliberately not reset; cache_valid gates every use of it.
  always_ff @(posedge clock) begin
    if (cache_wr) begin
      cache_w      <= cap_w;
      cache_signed <= cap_signed;
      cache_a      <= cap_a;
      cache_b      <= cap_b;
      cache_q      <= d_q;
      cache_r      <= d_r;
    end
  end

endmodule

// File: tb/tb_mdu_div_arbiter.sv
// Directed bench for mdu_div_arbiter: a 33-cycle divider model on the back side and a
// scoreboard queue of expected {owner, value} responses on the front side.
module tb_mdu_div_arbiter;

  localparam int XLEN = 64;

  logic            clock, reset, flush;
  logic            r0_valid, r0_ready, r0_w, r0_signed, r0_rem, r0_res_valid, r0_res_ready;
  logic [XLEN-1:0] r0_a, r0_b, r0_res;
  logic            r1_valid, r1_ready, r1_w, r1_signed, r1_rem, r1_res_valid, r1_res_ready;
  logic [XLEN-1:0] r1_a, r1_b, r1_res;
  logic            d_valid, d_ready, d_w, d_signed, d_done, d_ack;
  logic [XLEN-1:0] d_a, d_b, d_q, d_r;

  mdu_div_arbiter #(.XLEN(XLEN), .CACHE_EN(1'b1)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_w(r0_w), .r0_signed(r0_signed),
    .r0_rem(r0_rem), .r0_a(r0_a), .r0_b(r0_b), .r0_res_valid(r0_res_valid),
    .r0_res_ready(r0_res_ready), .r0_res(r0_res),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_w(r1_w), .r1_signed(r1_signed),
    .r1_rem(r1_rem), .r1_a(r1_a), .r1_b(r1_b), .r1_res_valid(r1_res_valid),
    .r1_res_ready(r1_res_ready), .r1_res(r1_res),
    .d_valid(d_valid), .d_ready(d_ready), .d_w(d_w), .d_signed(d_signed),
    .d_a(d_a), .d_b(d_b), .d_done(d_done), .d_q(d_q), .d_r(d_r), .d_ack(d_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic            owner;
    logic [XLEN-1:0] val;
  } exp_t;

  exp_t sb[$];
  int   passes = 0;
  int   total  = 0;
  int   hs_count = 0;
  int   both_ready = 0;
  int   div_cnt;
  logic div_busy;

  // Reference divider: RISC-V style results, W ops sign-extended from 32 bits.
  function automatic logic [XLEN-1:0] model_div(input logic w, sg, rem,
                                                input logic [XLEN-1:0] a, b);
    logic [31:0]     q32, r32;
    logic [XLEN-1:0] q64, r64;
    if (w) begin
      if (sg) begin
        q32 = $signed(a[31:0]) / $signed(b[31:0]);
        r32 = $signed(a[31:0]) % $signed(b[31:0]);
      end else begin
        q32 = a[31:0] / b[31:0];
        r32 = a[31:0] % b[31:0];
      end
      q64 = {{32{q32[31]}}, q32};
      r64 = {{32{r32[31]}}, r32};
    end else if (sg) begin
      q64 = $signed(a) / $signed(b);
      r64 = $signed(a) % $signed(b);
    end else begin
      q64 = a / b;
      r64 = a % b;
    end
    return rem ? r64 : q64;
  endfunction

  assign d_ready = !div_busy && !d_done;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_busy <= 1'b0;
      div_cnt  <= 0;
      d_done   <= 1'b0;
      d_q      <= '0;
      d_r      <= '0;
    end else begin
      if (d_done && d_ack) d_done <= 1'b0;
      if (d_valid && d_ready) begin
        div_busy <= 1'b1;
        div_cnt  <= 33;
        d_q      <= model_div(d_w, d_signed, 1'b0, d_a, d_b);
        d_r      <= model_div(d_w, d_signed, 1'b1, d_a, d_b);
        hs_count <= hs_count + 1;
      end else if (div_busy) begin
        div_cnt <= div_cnt - 1;
        if (div_cnt == 1) begin
          div_busy <= 1'b0;
          d_done   <= 1'b1;
        end
      end
    end
  end

  always @(negedge clock) if (r0_ready && r1_ready) both_ready++;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_req(input logic side, v, w, sg, rm, input logic [XLEN-1:0] a, b);
    if (!side) begin
      r0_valid = v; r0_w = w; r0_signed = sg; r0_rem = rm; r0_a = a; r0_b = b;
    end else begin
      r1_valid = v; r1_w = w; r1_signed = sg; r1_rem = rm; r1_a = a; r1_b = b;
    end
  endtask

  // Drive one request and hold it until accepted; returns at the negedge after the accept.
  task automatic send(input string tag, input logic side, w, sg, rm,
                      input logic [XLEN-1:0] a, b);
    int   n = 0;
    logic rdy;
    set_req(side, 1'b1, w, sg, rm, a, b);
    #1;
    rdy = side ? r1_ready : r0_ready;
    while (!rdy && n < 100) begin
      @(negedge clock); #1;
      n++;
      rdy = side ? r1_ready : r0_ready;
    end
    check({tag, "_accept"}, 64'(rdy), 64'(1));
    @(negedge clock);
    set_req(side, 1'b0, w, sg, rm, a, b);
  endtask

  task automatic push(input logic owner, input logic [XLEN-1:0] val);
    exp_t e;
    e.owner = owner;
    e.val   = val;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a response, compare against the scoreboard front, then take it.
  task automatic get_resp(input string tag, input int max_cyc, output int lat);
    int   n = 0;
    logic seen, own;
    exp_t e;
    while (!(r0_res_valid || r1_res_valid) && n < max_cyc) begin
      @(negedge clock);
      n++;
    end
    lat  = n;
    seen = r0_res_valid || r1_res_valid;
    check({tag, "_seen"}, 64'(seen), 64'(1));
    check({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'(1));
    if (seen && sb.size() > 0) begin
      e   = sb.pop_front();
      own = r1_res_valid;
      check({tag, "_owner"}, 64'(own), 64'(e.owner));
      check({tag, "_value"}, own ? r1_res : r0_res, e.val);
      check({tag, "_other_valid"}, 64'(own ? r0_res_valid : r1_res_valid), 64'(0));
      if (own) r1_res_ready = 1'b1; else r0_res_ready = 1'b1;
      @(negedge clock);
      r0_res_ready = 1'b0;
      r1_res_ready = 1'b0;
    end
  endtask

  initial begin
    int lat, hs0, cnt;
    reset = 1'b0; flush = 1'b0;
    r0_res_ready = 1'b0; r1_res_ready = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clock);
    check("rst_d_valid", 64'(d_valid), 64'(0));
    check("rst_d_ack", 64'(d_ack), 64'(0));
    check("rst_res_valid", 64'({r0_res_valid, r1_res_valid}), 64'(0));
    check("rst_res", r0_res, 64'(0));
    check("rst_d_a", d_a, 64'(0));
    reset = 1'b1;
    @(negedge clock);

    // Unsigned DIV, then REM on the same operands from the cache.
    hs0 = hs_count;
    push(1'b0, 64'd14);
    send("div_100_7", 1'b0, 1'b0, 1'b0, 1'b0, 64'd100, 64'd7);
    get_resp("div_100_7", 60, lat);
    check("div_100_7_hs", 64'(hs_count - hs0), 64'(1));
    hs0 = hs_count;
    push(1'b0, 64'd2);
    send("rem_100_7", 1'b0, 1'b0, 1'b0, 1'b1, 64'd100, 64'd7);
    get_resp("rem_100_7", 60, lat);
    check("rem_100_7_latency", 64'(lat), 64'(0));
    check("rem_100_7_hs", 64'(hs_count - hs0), 64'(0));

    // Signed W ops: DIVW -7/2, REMW from cache, then a miss on a new divisor.
    hs0 = hs_count;
    push(1'b0, 64'hFFFF_FFFF_FFFF_FFFD);
    send("divw_m7_2", 1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    get_resp("divw_m7_2", 60, lat);
    push(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    send("remw_m7_2", 1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    get_resp("remw_m7_2", 60, lat);
    check("remw_m7_2_latency", 64'(lat), 64'(0));
    check("w_pair_hs", 64'(hs_count - hs0), 64'(1));
    push(1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    send("divw_m7_3", 1'b0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3);
    get_resp("divw_m7_3", 60, lat);
    check("divw_m7_3_hs", 64'(hs_count - hs0), 64'(2));

    // An r1 request hands priority back to r0.
    push(1'b1, 64'd10);
    send("r1_div_50_5", 1'b1, 1'b0, 1'b0, 1'b0, 64'd50, 64'd5);
    get_resp("r1_div_50_5", 60, lat);

    // Both sides contend; r0 re-requests at once, yet r1 is served before r0's second.
    push(1'b0, 64'd100);
    push(1'b1, 64'd24);
    push(1'b0, 64'd4);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd1000, 64'd10);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd99, 64'd4);
    #1;
    check("rr1_r0_ready", 64'(r0_ready), 64'(1));
    check("rr1_r1_ready", 64'(r1_ready), 64'(0));
    @(negedge clock);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'd85, 64'd9);
    get_resp("rr_first", 60, lat);
    #1;
    check("rr2_r1_ready", 64'(r1_ready), 64'(1));
    check("rr2_r0_ready", 64'(r0_ready), 64'(0));
    @(negedge clock);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    get_resp("rr_second", 60, lat);
    #1;
    check("rr3_r0_ready", 64'(r0_ready), 64'(1));
    @(negedge clock);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    get_resp("rr_third", 60, lat);

    // Flush while the divider is busy: result drained and dropped, then rerun.
    hs0 = hs_count;
    send("flush_req", 1'b0, 1'b0, 1'b0, 1'b0, 64'd500, 64'd7);
    repeat (5) @(negedge clock);
    check("busy_d_ack", 64'(d_ack), 64'(1));
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("drain_d_ack", 64'(d_ack), 64'(1));
    cnt = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clock);
      if (r0_res_valid || r1_res_valid) cnt++;
    end
    check("drain_no_resp", 64'(cnt), 64'(0));
    check("drain_idle_ack", 64'(d_ack), 64'(0));
    push(1'b0, 64'd71);
    send("flush_rerun", 1'b0, 1'b0, 1'b0, 1'b0, 64'd500, 64'd7);
    get_resp("flush_rerun", 60, lat);
    check("flush_rerun_hs", 64'(hs_count - hs0), 64'(2));

    // Back-pressured response: stable, and the other side is locked out.
    push(1'b0, 64'd22);
    send("bp_req", 1'b0, 1'b0, 1'b0, 1'b0, 64'd200, 64'd9);
    cnt = 0;
    while (!r0_res_valid && cnt < 60) begin
      @(negedge clock);
      cnt++;
    end
    push(1'b1, 64'd5);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd30, 64'd6);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", 64'(r0_res_valid), 64'(1));
      check("bp_res", r0_res, 64'd22);
      check("bp_r1_ready", 64'(r1_ready), 64'(0));
      @(negedge clock);
    end
    get_resp("bp_resp", 5, lat);
    #1;
    check("bp_r1_ready_after", 64'(r1_ready), 64'(1));
    @(negedge clock);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    get_resp("bp_r1_resp", 60, lat);

    // Reset mid-BUSY clears outputs immediately and restores r0 priority.
    send("rst_req", 1'b1, 1'b0, 1'b0, 1'b0, 64'd77, 64'd7);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_d_ack", 64'(d_ack), 64'(0));
    check("midrst_d_valid", 64'(d_valid), 64'(0));
    check("midrst_res_valid", 64'({r0_res_valid, r1_res_valid}), 64'(0));
    check("midrst_res", r1_res, 64'(0));
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push(1'b0, 64'd8);
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd64, 64'd8);
    set_req(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'd64, 64'd4);
    #1;
    check("postrst_r0_ready", 64'(r0_ready), 64'(1));
    check("postrst_r1_ready", 64'(r1_ready), 64'(0));
    @(negedge clock);
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    get_resp("postrst_resp", 60, lat);

    check("never_both_ready", 64'(both_ready), 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
